// File: rtl/elite_i2c_slave_regfile.sv
// I2C slave with a byte-wide register file, oversampled SCL/SDA, burst read/write
// with pointer auto-increment and read-only slots fed from ro_in.
module elite_i2c_slave_regfile #(
  parameter logic [6:0]          I2C_ADDR = 7'h0A,
  parameter int                  NUM_REGS = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 8'h0A,
  parameter int                  FILT_LEN = 3,
  parameter int                  HOLD_CYC = 4
) (
  input  logic                        MClk,
  input  logic                        I2C_Rst_n,
  input  logic                        I2C_SCL,
  input  logic                        I2C_SDA_in,
  output logic                        I2C_SDA_oe,
  input  logic [NUM_REGS*8-1:0]       ro_in,
  output logic [NUM_REGS*8-1:0]       regs_out,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy,
  output logic                        stop_pulse
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, MACK, IGNORE
  } state_t;

  // Reset asserts asynchronously but is released in step with MClk
  logic rst_meta_reg, rst_n_int;
  always_ff @(posedge MClk or negedge I2C_Rst_n) begin
    if (!I2C_Rst_n) begin
      rst_meta_reg <= 1'b0;
      rst_n_int    <= 1'b0;
    end else begin
      rst_meta_reg <= 1'b1;
      rst_n_int    <= rst_meta_reg;
    end
  end

  logic [1:0] raw_lines, filt_lines;
  assign raw_lines = {I2C_SDA_in, I2C_SCL};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_filt
      logic          sync1_reg, sync2_reg, level_reg;
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge MClk or negedge rst_n_int) begin
        if (!rst_n_int) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          level_reg <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw_lines[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (int'(cnt_reg) + 1 >= FILT_LEN) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
      assign filt_lines[gi] = level_reg;
    end
  endgenerate

  logic scl_f, sda_f, scl_prev_reg, sda_prev_reg;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_f     = filt_lines[0];
  assign sda_f     = filt_lines[1];
  assign scl_rise  = scl_f & ~scl_prev_reg;
  assign scl_fall  = ~scl_f & scl_prev_reg;
  assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
  assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;

  logic [7:0] regs_reg [NUM_REGS];
  logic [7:0] reg_view [NUM_REGS];
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_view
      assign reg_view[gi] = RO_MASK[gi] ? ro_in[gi*8 +: 8] : regs_reg[gi];
      assign regs_out[gi*8 +: 8] = reg_view[gi];
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next, tx_reg, tx_next;
  logic [AW-1:0] ptr_reg, ptr_next, ptr_inc;
  logic          rw_reg, rw_next, reg_ok_reg, reg_ok_next, mack_reg, mack_next;
  logic          oe_pend_reg, oe_pend_next, sda_oe_reg, sda_oe_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          busy_reg, busy_next, stop_pulse_reg, stop_pulse_next;
  logic          wr_strobe_reg, wr_strobe_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]    wr_data_reg, wr_data_next;

  assign ptr_inc = (ptr_reg == AW'(NUM_REGS - 1)) ? '0 : ptr_reg + 1'b1;

  always_ff @(posedge MClk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      scl_prev_reg   <= 1'b1;
      sda_prev_reg   <= 1'b1;
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      tx_reg         <= '0;
      ptr_reg        <= '0;
      rw_reg         <= 1'b0;
      reg_ok_reg     <= 1'b0;
      mack_reg       <= 1'b1;
      oe_pend_reg    <= 1'b0;
      sda_oe_reg     <= 1'b0;
      hold_cnt_reg   <= '0;
      busy_reg       <= 1'b0;
      stop_pulse_reg <= 1'b0;
      wr_strobe_reg  <= 1'b0;
      wr_addr_reg    <= '0;
      wr_data_reg    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      scl_prev_reg   <= scl_f;
      sda_prev_reg   <= sda_f;
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      tx_reg         <= tx_next;
      ptr_reg        <= ptr_next;
      rw_reg         <= rw_next;
      reg_ok_reg     <= reg_ok_next;
      mack_reg       <= mack_next;
      oe_pend_reg    <= oe_pend_next;
      sda_oe_reg     <= sda_oe_next;
      hold_cnt_reg   <= hold_cnt_next;
      busy_reg       <= busy_next;
      stop_pulse_reg <= stop_pulse_next;
      wr_strobe_reg  <= wr_strobe_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
      if (wr_strobe_next) regs_reg[wr_addr_next] <= wr_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    tx_next         = tx_reg;
    ptr_next        = ptr_reg;
    rw_next         = rw_reg;
    reg_ok_next     = reg_ok_reg;
    mack_next       = mack_reg;
    oe_pend_next    = oe_pend_reg;
    hold_cnt_next   = (hold_cnt_reg != '0) ? hold_cnt_reg - 1'b1 : '0;
    sda_oe_next     = (hold_cnt_reg == HW'(1)) ? oe_pend_reg : sda_oe_reg;
    busy_next       = busy_reg;
    stop_pulse_next = 1'b0;
    wr_strobe_next  = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;

    if (stop_det) begin
      state_next      = IDLE;
      sda_oe_next     = 1'b0;
      oe_pend_next    = 1'b0;
      hold_cnt_next   = '0;
      stop_pulse_next = busy_reg;
      busy_next       = 1'b0;
    end else if (start_det) begin
      // Abandons any partial byte; nothing is committed before its 8th bit
      state_next    = ADDR;
      bit_cnt_next  = '0;
      sda_oe_next   = 1'b0;
      oe_pend_next  = 1'b0;
      hold_cnt_next = '0;
    end else if (scl_rise) begin
      case (state_reg)
        ADDR, REG, WDATA: begin
          shift_next   = {shift_reg[6:0], sda_f};
          bit_cnt_next = bit_cnt_reg + 1'b1;
        end
        RDATA:   bit_cnt_next = bit_cnt_reg + 1'b1;
        MACK:    mack_next = sda_f;
        default: ;
      endcase
    end else if (scl_fall) begin
      // Every SDA decision is made here and applied HOLD_CYC cycles later
      hold_cnt_next = HW'(HOLD_CYC);
      case (state_reg)
        ADDR: if (bit_cnt_reg == 4'd8) begin
          if (shift_reg[7:1] == I2C_ADDR) begin
            state_next   = ADDR_ACK;
            rw_next      = shift_reg[0];
            oe_pend_next = 1'b1;
            busy_next    = 1'b1;
          end else begin
            state_next   = IGNORE;
            oe_pend_next = 1'b0;
            busy_next    = 1'b0;
          end
        end
        ADDR_ACK: begin
          bit_cnt_next = '0;
          if (rw_reg) begin
            state_next   = RDATA;
            tx_next      = reg_view[ptr_reg];
            oe_pend_next = ~reg_view[ptr_reg][7];
          end else begin
            state_next   = REG;
            oe_pend_next = 1'b0;
          end
        end
        REG: if (bit_cnt_reg == 4'd8) begin
          state_next = REG_ACK;
          if (int'(shift_reg) < NUM_REGS) begin
            reg_ok_next  = 1'b1;
            ptr_next     = shift_reg[AW-1:0];
            oe_pend_next = 1'b1;
          end else begin
            reg_ok_next  = 1'b0;
            oe_pend_next = 1'b0;
          end
        end
        REG_ACK: begin
          bit_cnt_next = '0;
          oe_pend_next = 1'b0;
          state_next   = reg_ok_reg ? WDATA : IGNORE;
        end
        WDATA: if (bit_cnt_reg == 4'd8) begin
          state_next   = WDATA_ACK;
          oe_pend_next = 1'b1;
          ptr_next     = ptr_inc;
          if (!RO_MASK[ptr_reg]) begin
            wr_strobe_next = 1'b1;
            wr_addr_next   = ptr_reg;
            wr_data_next   = shift_reg;
          end
        end
        WDATA_ACK: begin
          state_next   = WDATA;
          bit_cnt_next = '0;
          oe_pend_next = 1'b0;
        end
        RDATA: begin
          if (bit_cnt_reg == 4'd8) begin
            state_next   = MACK;
            oe_pend_next = 1'b0;
          end else begin
            oe_pend_next = ~tx_reg[6];
            tx_next      = {tx_reg[6:0], 1'b0};
          end
        end
        MACK: begin
          if (!mack_reg) begin
            state_next   = RDATA;
            bit_cnt_next = '0;
            ptr_next     = ptr_inc;
            tx_next      = reg_view[ptr_inc];
            oe_pend_next = ~reg_view[ptr_inc][7];
          end else begin
            state_next   = IGNORE;
            oe_pend_next = 1'b0;
          end
        end
        default: oe_pend_next = 1'b0;
      endcase
    end
  end

  assign I2C_SDA_oe = sda_oe_reg;
  assign busy       = busy_reg;
  assign stop_pulse = stop_pulse_reg;
  assign wr_strobe  = wr_strobe_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_data    = wr_data_reg;

endmodule

// File: tb/tb_elite_i2c_slave_regfile.sv
// Directed bench: a bit-banged I2C master drives the slave through writes, bursts,
// read-only slots, repeated START, address/register rejection, SCL glitch and reset.
module tb_elite_i2c_slave_regfile;

  localparam int Q = 25;

  logic        MClk = 1'b0;
  logic        I2C_Rst_n;
  logic        scl_m, sda_m;
  logic        I2C_SDA_oe;
  logic [63:0] ro_in, regs_out;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, stop_pulse;
  wire         sda_line = sda_m & ~I2C_SDA_oe;

  always #5 MClk = ~MClk;

  elite_i2c_slave_regfile dut (
    .MClk       (MClk),
    .I2C_Rst_n  (I2C_Rst_n),
    .I2C_SCL    (scl_m),
    .I2C_SDA_in (sda_line),
    .I2C_SDA_oe (I2C_SDA_oe),
    .ro_in      (ro_in),
    .regs_out   (regs_out),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .stop_pulse (stop_pulse)
  );

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0, stop_cnt = 0, oe_cyc = 0, busy_cyc = 0;
  logic [2:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  always @(posedge MClk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_wa    <= wr_addr;
      last_wd    <= wr_data;
    end
    if (stop_pulse) stop_cnt <= stop_cnt + 1;
    if (I2C_SDA_oe) oe_cyc <= oe_cyc + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  logic [7:0] ro_mask_tb = 8'h0A;
  logic [7:0] er [8];

  function automatic logic [63:0] exp_out();
    logic [63:0] v;
    for (int i = 0; i < 8; i++)
      v[i*8 +: 8] = ro_mask_tb[i] ? ro_in[i*8 +: 8] : er[i];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge MClk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  // One SCL period; s is the bus level sampled mid-high
  task automatic clk_bit(input logic b, input bit glitch, output logic s);
    sda_m = b;
    tick(8);
    if (glitch) begin
      scl_m = 1'b1; tick(2);
      scl_m = 1'b0; tick(Q - 10);
    end else begin
      tick(Q - 8);
    end
    scl_m = 1'b1; tick(Q);
    s = sda_line;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch && (i == 4), s);
    clk_bit(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic s;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s);
      v = {v[6:0], s};
    end
    clk_bit(~mack, 1'b0, s);
  endtask

  logic       ack;
  logic [7:0] rb;
  int         s0, p0, o0, b0;

  initial begin
    for (int i = 0; i < 8; i++) er[i] = 8'h00;
    ro_in     = 64'h00000000_5C00_9900;
    sda_m     = 1'b1;
    scl_m     = 1'b1;
    I2C_Rst_n = 1'b0;
    tick(5);
    chk("rst_oe", I2C_SDA_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_regs", regs_out, exp_out());
    I2C_Rst_n = 1'b1;
    tick(10);

    // Single write of 0xA5 to register 2
    s0 = strobe_cnt; p0 = stop_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack); chk("t1_ack_addr", ack, 1);
    send_byte(8'h02, 0, ack); chk("t1_ack_reg", ack, 1);
    send_byte(8'hA5, 0, ack); chk("t1_ack_data", ack, 1);
    chk("t1_busy_mid", busy, 1);
    i2c_stop();
    er[2] = 8'hA5;
    chk("t1_strobes", strobe_cnt - s0, 1);
    chk("t1_waddr", last_wa, 2);
    chk("t1_wdata", last_wd, 8'hA5);
    chk("t1_reg2", regs_out[23:16], 8'hA5);
    chk("t1_stop_pulse", stop_cnt - p0, 1);
    chk("t1_busy_end", busy, 0);

    // Burst write wrapping 6 -> 7 -> 0
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack);
    send_byte(8'h06, 0, ack);
    send_byte(8'h11, 0, ack); chk("t2_ack0", ack, 1);
    send_byte(8'h22, 0, ack); chk("t2_ack1", ack, 1);
    send_byte(8'h33, 0, ack); chk("t2_ack2", ack, 1);
    i2c_stop();
    er[6] = 8'h11; er[7] = 8'h22; er[0] = 8'h33;
    chk("t2_strobes", strobe_cnt - s0, 3);
    chk("t2_last_waddr", last_wa, 0);
    chk("t2_regs", regs_out, exp_out());

    // Register 3 is read-only: byte ACKed but dropped; next byte lands in register 4
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack);
    send_byte(8'h03, 0, ack);
    send_byte(8'hFF, 0, ack); chk("t3_ack_ro", ack, 1);
    chk("t3_no_strobe_ro", strobe_cnt - s0, 0);
    send_byte(8'h3C, 0, ack); chk("t3_ack_r4", ack, 1);
    i2c_stop();
    er[4] = 8'h3C;
    chk("t3_strobes", strobe_cnt - s0, 1);
    chk("t3_waddr", last_wa, 4);
    chk("t3_regs", regs_out, exp_out());

    // Set pointer to 3, repeated START, read two bytes
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack);
    send_byte(8'h03, 0, ack); chk("t3r_ack_reg", ack, 1);
    i2c_rstart();
    send_byte(8'h15, 0, ack); chk("t3r_ack_addr", ack, 1);
    recv_byte(1'b1, rb); chk("t3r_byte0", rb, 8'h5C);
    recv_byte(1'b0, rb); chk("t3r_byte1", rb, 8'h3C);
    tick(Q);
    chk("t3r_released", I2C_SDA_oe, 0);
    chk("t3r_busy", busy, 1);
    i2c_stop();
    chk("t3r_no_strobe", strobe_cnt - s0, 0);

    // Wrong address: never drive SDA, never busy
    o0 = oe_cyc; b0 = busy_cyc; p0 = stop_cnt;
    i2c_start();
    send_byte(8'h16, 0, ack); chk("t4_nack_addr", ack, 0);
    send_byte(8'h55, 0, ack); chk("t4_nack_data", ack, 0);
    i2c_stop();
    chk("t4_oe_cycles", oe_cyc - o0, 0);
    chk("t4_busy_cycles", busy_cyc - b0, 0);
    chk("t4_no_stop_pulse", stop_cnt - p0, 0);

    // Register index out of range
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack); chk("t5_ack_addr", ack, 1);
    send_byte(8'h09, 0, ack); chk("t5_nack_reg", ack, 0);
    send_byte(8'h77, 0, ack); chk("t5_nack_data", ack, 0);
    i2c_stop();
    chk("t5_no_strobe", strobe_cnt - s0, 0);
    chk("t5_regs", regs_out, exp_out());

    // Short SCL glitch inside the data byte is filtered out
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack);
    send_byte(8'h05, 0, ack);
    send_byte(8'h6B, 1, ack); chk("t6_ack", ack, 1);
    i2c_stop();
    er[5] = 8'h6B;
    chk("t6_strobes", strobe_cnt - s0, 1);
    chk("t6_wdata", last_wd, 8'h6B);
    chk("t6_regs", regs_out, exp_out());

    // Read from pointer 6 (0x11, MSB 0 so SDA is driven), then reset mid-byte
    i2c_start();
    send_byte(8'h15, 0, ack); chk("t7_ack", ack, 1);
    chk("t7_oe_driving", I2C_SDA_oe, 1);
    chk("t7_busy", busy, 1);
    I2C_Rst_n = 1'b0;
    #1;
    chk("t7_oe_reset", I2C_SDA_oe, 0);
    chk("t7_busy_reset", busy, 0);
    for (int i = 0; i < 8; i++) er[i] = 8'h00;
    tick(3);
    chk("t7_regs_reset", regs_out, exp_out());
    scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    I2C_Rst_n = 1'b1;
    tick(10);
    chk("t7_oe_after", I2C_SDA_oe, 0);

    // Fresh transaction after reset starts from IDLE
    s0 = strobe_cnt;
    i2c_start();
    send_byte(8'h14, 0, ack); chk("t8_ack_addr", ack, 1);
    send_byte(8'h02, 0, ack);
    send_byte(8'h42, 0, ack); chk("t8_ack_data", ack, 1);
    i2c_stop();
    er[2] = 8'h42;
    chk("t8_strobes", strobe_cnt - s0, 1);
    chk("t8_waddr", last_wa, 2);
    chk("t8_regs", regs_out, exp_out());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elite_i2c_slave_regfile.md
Name: elite_i2c_slave_regfile

Overview:
Second-generation I2C slave with an on-chip register file, fully synchronous to MClk. SCL and SDA are oversampled, so the block needs no combinational start/stop loop and no SCL-clocked logic. Register count, device address and input filtering are parametrised. Supports multi-byte burst read and write with pointer auto-increment, repeated START, and read-only status registers.

Parameters:
I2C_ADDR, 7'h0A, 7-bit device address to match
NUM_REGS, 8, number of 8-bit registers (2..256)
RO_MASK, 8'h0A, per-register bit; 1 = read-only (value taken from ro_in)
FILT_LEN, 3, consecutive equal samples required to accept a new SCL/SDA level
HOLD_CYC, 4, MClk cycles after accepted SCL fall before SDA output changes

Ports:
MClk  in  1  system clock, 50 MHz
I2C_Rst_n  in  1  asynchronous active-low reset
I2C_SCL  in  1  bus clock (raw pin)
I2C_SDA_in  in  1  bus data (raw pin)
I2C_SDA_oe  out  1  1 = drive SDA low (open-drain); 0 = release
ro_in  in  NUM_REGS*8  live values for read-only registers
regs_out  out  NUM_REGS*8  current register-file contents (RO slots show ro_in)
wr_strobe  out  1  one-cycle pulse per accepted data write
wr_addr  out  clog2(NUM_REGS)  register index of the write
wr_data  out  8  data of the write
busy  out  1  addressed transaction in progress
stop_pulse  out  1  one-cycle pulse on STOP following an addressed transaction

Behaviour:
- Reset (async assert, sync deassert internally): SDA_oe=0, busy=0, strobes=0, wr_addr=0, wr_data=0, pointer=0, all writable registers=8'h00, FSM=IDLE.
- Input path: 2-FF synchroniser, then FILT_LEN glitch filter per line. Filtered lines scl_f/sda_f; edge flags are derived from their previous values.
- START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1. Both are detected in any state. START (including repeated START) goes to ADDR. STOP goes to IDLE, releases SDA and pulses stop_pulse if busy.
- Bits are sampled on the scl_f rising edge. SDA_oe changes only HOLD_CYC cycles after an scl_f falling edge.
- FSM: IDLE -> ADDR (8 bits) -> ADDR_ACK.
  - Address mismatch: go to IGNORE until START/STOP; never drive SDA.
  - Match with R/W=0: ACK, then REG.
  - Match with R/W=1: ACK, then RDATA.
  - REG (8 bits) -> REG_ACK: value < NUM_REGS loads the pointer and ACKs, then WDATA. Otherwise NACK, then IGNORE.
  - WDATA -> WDATA_ACK: always ACK. If the pointer register is writable, update it, pulse wr_strobe with wr_addr=pointer and wr_data=byte in the ACK cycle. If read-only, discard the byte and do not strobe. Pointer then increments.
  - RDATA: the byte register[pointer] (or ro_in slice) is latched at the SCL fall that ends the ACK, then shifted MSB first. Drive 0 bits low; release for 1 bits.
  - RDATA -> MACK: release SDA and sample the master's ACK. ACK: pointer increments, back to RDATA. NACK: IGNORE until STOP/START.
- Pointer wraps from NUM_REGS-1 to 0. The pointer persists across transactions, so a read without a register phase continues from the last pointer.
- busy=1 from address-match ACK until STOP, mismatch-triggered IGNORE, or reset.
- A START mid-byte aborts the byte. No partial write is committed.
- Reset mid-transaction releases SDA immediately.

Test Plan:
- Write 0x14,reg 0x02,data 0xA5,STOP -> three ACKs; wr_strobe once with wr_addr=2, wr_data=0xA5; regs_out[23:16]=0xA5; stop_pulse.
- Burst write reg 0x06, data 0x11,0x22,0x33 (NUM_REGS=8) -> regs 6=0x11, 7=0x22, 0=0x33 (wrap); three strobes.
- Write reg 0x03 (RO, ro_in slot=0x5C), data 0xFF; repeated START; read 0x15, two bytes with master ACK then NACK -> byte ACKed, no strobe; read returns 0x5C then reg4 value; SDA released after NACK.
- Address 0x16 (0x0B) -> SDA_oe never asserted, busy stays 0.
- Register byte 0x09 -> NACK on 9th clock; subsequent data not ACKed; no strobe.
- SCL glitch of FILT_LEN-1 cycles mid-byte -> ignored, byte received correctly. Reset asserted during RDATA -> SDA_oe=0 within reset assertion, FSM IDLE.
